// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler sharing one ultrasonic ranging engine between several
// HC-SR04-style sensors; each measurement is handed downstream on a valid/ready port.
module ultrasonic_scan_scheduler #(
  parameter int NUM_SENSORS     = 2,
  parameter int TRIG_CYCLES     = 120,
  parameter int TIMEOUT_CYCLES  = 360000,
  parameter int COOLDOWN_CYCLES = 120000,
  parameter int CNT_W           = 20,
  localparam int IDW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   hw_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor_mask,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDW-1:0]         res_id,
  output logic [CNT_W-1:0]       res_count,
  output logic                   res_timeout,
  output logic                   busy
);

  // state       | meaning
  // S_IDLE      | parked, waiting for enable with a non-empty mask
  // S_SELECT    | pick next masked sensor after the last one served
  // S_TRIGGER   | drive trig[sel] for TRIG_CYCLES clocks
  // S_WAIT_RISE | wait for a fresh echo rising edge, bounded by timeout
  // S_MEASURE   | count echo high time, saturating at TIMEOUT_CYCLES
  // S_REPORT    | hold result word until the consumer takes it
  // S_COOLDOWN  | let ringing die out before the next trigger
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_TRIGGER, S_WAIT_RISE, S_MEASURE, S_REPORT, S_COOLDOWN
  } state_t;

  localparam int MAX_TA = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_T  = (MAX_TA > COOLDOWN_CYCLES) ? MAX_TA : COOLDOWN_CYCLES;
  localparam int TMR_W  = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] TRIG_LOAD = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] RISE_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] COOL_LOAD = TMR_W'(COOLDOWN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDW-1:0]   LAST_RST  = IDW'(NUM_SENSORS - 1);

  state_t                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [IDW-1:0]         sel_q, sel_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [NUM_SENSORS-1:0] trig_q, trig_d;
  logic                   res_valid_q, res_valid_d;
  logic [IDW-1:0]         res_id_q, res_id_d;
  logic [CNT_W-1:0]       res_count_q, res_count_d;
  logic                   res_timeout_q, res_timeout_d;
  logic                   busy_q, busy_d;
  logic [NUM_SENSORS-1:0] sync1_q, sync1_d;
  logic [NUM_SENSORS-1:0] sync2_q, sync2_d;
  logic [NUM_SENSORS-1:0] prev_q, prev_d;

  logic           nxt_found;
  logic [IDW-1:0] nxt_idx;
  int             cand;
  logic           echo_now;
  logic           echo_rise;

  // Scan forward from the sensor after last_q, wrapping, for the first masked-in one.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_SENSORS; i++) begin
      cand = (int'(last_q) + i) % NUM_SENSORS;
      if (!nxt_found && sensor_mask[IDW'(cand)]) begin
        nxt_found = 1'b1;
        nxt_idx   = IDW'(cand);
      end
    end
  end

  assign echo_now  = sync2_q[sel_q];
  assign echo_rise = echo_now & ~prev_q[sel_q];

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    count_d       = count_q;
    sel_d         = sel_q;
    last_d        = last_q;
    trig_d        = trig_q;
    res_valid_d   = res_valid_q;
    res_id_d      = res_id_q;
    res_count_d   = res_count_q;
    res_timeout_d = res_timeout_q;
    sync1_d       = echo;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;

    case (state_q)
      S_IDLE: begin
        if (enable && (sensor_mask != '0)) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (nxt_found) begin
          sel_d           = nxt_idx;
          trig_d          = '0;
          trig_d[nxt_idx] = 1'b1;
          timer_d         = TRIG_LOAD;
          state_d         = S_TRIGGER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TRIGGER: begin
        if (timer_q == '0) begin
          trig_d  = '0;
          timer_d = RISE_LOAD;
          state_d = S_WAIT_RISE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_WAIT_RISE: begin
        // Edge, not level: an echo still high from before the trigger is not a reply.
        if (echo_rise) begin
          count_d = CNT_ONE;
          state_d = S_MEASURE;
        end else if (timer_q == '0) begin
          res_id_d      = sel_q;
          res_count_d   = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = S_REPORT;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_MEASURE: begin
        if (!echo_now) begin
          res_id_d      = sel_q;
          res_count_d   = count_q;
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = S_REPORT;
        end else if ((count_q + CNT_ONE) == CNT_SAT) begin
          res_id_d      = sel_q;
          res_count_d   = CNT_SAT;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = S_REPORT;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          last_d      = sel_q;
          timer_d     = COOL_LOAD;
          state_d     = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (timer_q == '0) begin
          state_d = enable ? S_SELECT : S_IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      count_q       <= '0;
      sel_q         <= '0;
      last_q        <= LAST_RST;
      trig_q        <= '0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_count_q   <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      prev_q        <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      count_q       <= count_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      trig_q        <= trig_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_count_q   <= res_count_d;
      res_timeout_q <= res_timeout_d;
      busy_q        <= busy_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
    end
  end

  assign trig        = trig_q;
  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_count   = res_count_q;
  assign res_timeout = res_timeout_q;
  assign busy        = busy_q;

endmodule
